// File: rtl/mr_latch_bank.sv
// mr_latch_bank
//   Multi-channel latch/buffer bank. Each channel synchronises its raw input,
//   glitch-filters it, then drives dout in transparent, latch (4-phase capture
//   handshake), toggle or hold mode.
//
//   Optional feature macro: MR_LATCH_INVERT_EN
//     When defined, adds input inv_mask; din ^ inv_mask feeds the synchroniser.
//
// Ports:
//   clk       in   clock
//   rst_n     in   synchronous active-low reset
//   ena       in   1 = operate, 0 = freeze filter, outputs and capture FSM
//   din       in   [CHANNELS-1:0] raw asynchronous channel inputs
//   inv_mask  in   [CHANNELS-1:0] input inversion mask (MR_LATCH_INVERT_EN only)
//   mode      in   [1:0] 00 transparent, 01 latch, 10 toggle, 11 hold
//   filt_len  in   [FILT_BITS-1:0] glitch-filter length (0 = no filtering)
//   cap_req   in   capture request (4-phase handshake)
//   cap_ack   out  capture acknowledge
//   dout      out  [CHANNELS-1:0] channel outputs
//   chg       out  [CHANNELS-1:0] one-cycle pulse per dout bit that changed
module mr_latch_bank #(
  parameter int CHANNELS    = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_BITS   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [CHANNELS-1:0]  din,
`ifdef MR_LATCH_INVERT_EN
  input  logic [CHANNELS-1:0]  inv_mask,
`endif
  input  logic [1:0]           mode,
  input  logic [FILT_BITS-1:0] filt_len,
  input  logic                 cap_req,
  output logic                 cap_ack,
  output logic [CHANNELS-1:0]  dout,
  output logic [CHANNELS-1:0]  chg
);

  localparam logic [1:0] MODE_TRANS  = 2'b00;
  localparam logic [1:0] MODE_LATCH  = 2'b01;
  localparam logic [1:0] MODE_TOGGLE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_ACK     = 2'd2
  } state_t;

  logic [CHANNELS-1:0]                  din_src_s;
  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;
  logic [CHANNELS-1:0]                  sync_s;
  logic [CHANNELS-1:0]                  stable_q, stable_d;
  logic [CHANNELS-1:0]                  stable_prev_q, stable_prev_d;
  logic [CHANNELS-1:0][FILT_BITS-1:0]   cnt_q, cnt_d;
  logic [CHANNELS-1:0]                  dout_q, dout_d;
  logic [CHANNELS-1:0]                  chg_q, chg_d;
  logic                                 cap_ack_q, cap_ack_d;
  state_t                               state_q, state_d;

  // Source for the synchroniser (optionally inverted per channel)
  always_comb begin
`ifdef MR_LATCH_INVERT_EN
    din_src_s = din ^ inv_mask;
`else
    din_src_s = din;
`endif
  end

  // Synchroniser shift chain; keeps sampling regardless of ena
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din_src_s};
    sync_s = sync_q[SYNC_STAGES-1];
  end

  // Glitch filter: accept a new level after filt_len+1 consecutive differing cycles.
  // filt_len is compared live, so a counter already past a reduced value wraps.
  always_comb begin
    stable_d      = stable_q;
    cnt_d         = cnt_q;
    stable_prev_d = stable_prev_q;
    if (ena) begin
      stable_prev_d = stable_q;
      for (int i = 0; i < CHANNELS; i++) begin
        if (sync_s[i] == stable_q[i]) begin
          cnt_d[i] = {FILT_BITS{1'b0}};
        end else if (cnt_q[i] == filt_len) begin
          stable_d[i] = sync_s[i];
          cnt_d[i]    = {FILT_BITS{1'b0}};
        end else begin
          cnt_d[i] = cnt_q[i] + {{(FILT_BITS-1){1'b0}}, 1'b1};
        end
      end
    end else begin
      stable_d = stable_q;
    end
  end

  // Capture FSM next state and output-mode selection
  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    if (ena) begin
      case (state_q)
        ST_IDLE: begin
          if (cap_req && (mode == MODE_LATCH)) state_d = ST_CAPTURE;
          else                                 state_d = ST_IDLE;
        end
        ST_CAPTURE: state_d = ST_ACK;
        ST_ACK: begin
          if (cap_req) state_d = ST_ACK;
          else         state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase

      // A capture always completes, whatever mode is selected meanwhile
      if (state_q == ST_CAPTURE) begin
        dout_d = stable_q;
      end else begin
        case (mode)
          MODE_TRANS:  dout_d = stable_q;
          // Toggle only on filtered rising edges
          MODE_TOGGLE: dout_d = dout_q ^ (stable_q & ~stable_prev_q);
          default:     dout_d = dout_q;
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // Change pulses and acknowledge; both frozen/forced while ena is low
  always_comb begin
    if (ena) chg_d = dout_d ^ dout_q;
    else     chg_d = {CHANNELS{1'b0}};
    cap_ack_d = (state_d == ST_ACK);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q        <= {(SYNC_STAGES*CHANNELS){1'b0}};
      stable_q      <= {CHANNELS{1'b0}};
      stable_prev_q <= {CHANNELS{1'b0}};
      cnt_q         <= {(CHANNELS*FILT_BITS){1'b0}};
      dout_q        <= {CHANNELS{1'b0}};
      chg_q         <= {CHANNELS{1'b0}};
      cap_ack_q     <= 1'b0;
      state_q       <= ST_IDLE;
    end else begin
      sync_q        <= sync_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
      cnt_q         <= cnt_d;
      dout_q        <= dout_d;
      chg_q         <= chg_d;
      cap_ack_q     <= cap_ack_d;
      state_q       <= state_d;
    end
  end

  assign dout    = dout_q;
  assign chg     = chg_q;
  assign cap_ack = cap_ack_q;

endmodule

// File: tb/tb_mr_latch_bank.sv
// Scoreboard bench for mr_latch_bank (CHANNELS=8, SYNC_STAGES=2, FILT_BITS=4).
// Stimulus pushes expected outputs tagged with the clock count at which they
// must appear; a monitor on the falling edge pops and compares them.
module tb_mr_latch_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] din = 8'h00;
  logic [1:0] mode = 2'b00;
  logic [3:0] filt_len = 4'd0;
  logic       cap_req = 1'b0;
  logic       cap_ack;
  logic [7:0] dout;
  logic [7:0] chg;
`ifdef MR_LATCH_INVERT_EN
  logic [7:0] inv_mask = 8'h00;
`endif

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int         cyc;
    string      name;
    logic [7:0] d;
    logic [7:0] dm;
    logic [7:0] c;
    logic [7:0] cm;
    logic       a;
    logic       am;
  } exp_t;

  exp_t sb[$];

  mr_latch_bank #(.CHANNELS(8), .SYNC_STAGES(2), .FILT_BITS(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .din      (din),
`ifdef MR_LATCH_INVERT_EN
    .inv_mask (inv_mask),
`endif
    .mode     (mode),
    .filt_len (filt_len),
    .cap_req  (cap_req),
    .cap_ack  (cap_ack),
    .dout     (dout),
    .chg      (chg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due at this clock count
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        n_vec++;
        if (sb[i].cyc < cyc) begin
          n_bad++;
          $display("FAIL %s missed check at cyc %0d (now %0d)", sb[i].name, sb[i].cyc, cyc);
        end else if (((dout & sb[i].dm) !== (sb[i].d & sb[i].dm)) ||
                     ((chg & sb[i].cm) !== (sb[i].c & sb[i].cm)) ||
                     (sb[i].am && (cap_ack !== sb[i].a))) begin
          n_bad++;
          $display("FAIL %s cyc=%0d dout=%h want %h (mask %h) chg=%h want %h (mask %h) cap_ack=%b want %b",
                   sb[i].name, cyc, dout, sb[i].d, sb[i].dm, chg, sb[i].c, sb[i].cm,
                   cap_ack, sb[i].a);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_at(input int k, input string nm,
                        input logic [7:0] d, input logic [7:0] c, input logic a);
    exp_t e;
    e.cyc  = cyc + k;
    e.name = nm;
    e.d    = d;
    e.dm   = 8'hFF;
    e.c    = c;
    e.cm   = 8'hFF;
    e.a    = a;
    e.am   = 1'b1;
    sb.push_back(e);
  endtask

  initial begin
    // Reset with din high
    din = 8'hFF;
    tick(3);
    exp_at(0, "reset", 8'h00, 8'h00, 1'b0);
    tick(1);
    // Release: dout rises exactly 4 edges later, chg for one cycle
    rst_n = 1'b1;
    exp_at(3, "rel_pre", 8'h00, 8'h00, 1'b0);
    exp_at(4, "rel_dout", 8'hFF, 8'hFF, 1'b0);
    exp_at(5, "rel_chg1", 8'hFF, 8'h00, 1'b0);
    tick(6);

    // Back to zero, then glitch filter with filt_len = 3
    din = 8'h00;
    exp_at(8, "settle0", 8'h00, 8'h00, 1'b0);
    tick(8);
    filt_len = 4'd3;
    din = 8'h01;
    exp_at(4, "glitch3_a", 8'h00, 8'h00, 1'b0);
    exp_at(7, "glitch3_b", 8'h00, 8'h00, 1'b0);
    exp_at(10, "glitch3_c", 8'h00, 8'h00, 1'b0);
    tick(3);
    din = 8'h00;
    tick(9);
    din = 8'h01;
    exp_at(6, "filt4_pre", 8'h00, 8'h00, 1'b0);
    exp_at(7, "filt4_rise", 8'h01, 8'h01, 1'b0);
    exp_at(8, "filt4_hold", 8'h01, 8'h00, 1'b0);
    exp_at(11, "filt4_fall", 8'h00, 8'h01, 1'b0);
    tick(4);
    din = 8'h00;
    tick(9);

    // Latch handshake
    filt_len = 4'd0;
    mode = 2'b01;
    din = 8'hA5;
    exp_at(6, "latch_hold", 8'h00, 8'h00, 1'b0);
    tick(6);
    cap_req = 1'b1;
    exp_at(1, "cap_wait", 8'h00, 8'h00, 1'b0);
    exp_at(2, "cap_load", 8'hA5, 8'hA5, 1'b1);
    tick(2);
    din = 8'h5A;
    exp_at(6, "cap_nosecond", 8'hA5, 8'h00, 1'b1);
    tick(6);
    cap_req = 1'b0;
    exp_at(1, "ack_drop", 8'hA5, 8'h00, 1'b0);
    tick(2);
    mode = 2'b11;
    cap_req = 1'b1;
    exp_at(3, "mode11_ignore", 8'hA5, 8'h00, 1'b0);
    tick(4);
    cap_req = 1'b0;

    // Toggle on din[3]; dout[3] starts at 0
    din = 8'h00;
    exp_at(6, "hold11", 8'hA5, 8'h00, 1'b0);
    tick(6);
    mode = 2'b10;
    exp_at(4, "tog1", 8'hAD, 8'h08, 1'b0);
    exp_at(5, "tog1_end", 8'hAD, 8'h00, 1'b0);
    exp_at(8, "tog2", 8'hA5, 8'h08, 1'b0);
    exp_at(12, "tog3", 8'hAD, 8'h08, 1'b0);
    exp_at(13, "tog3_end", 8'hAD, 8'h00, 1'b0);
    for (int p = 0; p < 3; p++) begin
      din = 8'h08;
      tick(2);
      din = 8'h00;
      tick(2);
    end
    tick(2);

    // ena freeze in transparent mode
    mode = 2'b00;
    exp_at(1, "trans_back", 8'h00, 8'hAD, 1'b0);
    exp_at(6, "trans_idle", 8'h00, 8'h00, 1'b0);
    tick(6);
    ena = 1'b0;
    din = 8'h0F;
    exp_at(3, "freeze3", 8'h00, 8'h00, 1'b0);
    exp_at(8, "freeze8", 8'h00, 8'h00, 1'b0);
    tick(8);
    ena = 1'b1;
    exp_at(1, "unfreeze1", 8'h00, 8'h00, 1'b0);
    exp_at(2, "unfreeze2", 8'h0F, 8'h0F, 1'b0);
    tick(3);

    // Reset while in ACK
    mode = 2'b01;
    cap_req = 1'b1;
    exp_at(2, "pre_rst_ack", 8'h0F, 8'h00, 1'b1);
    tick(2);
    rst_n = 1'b0;
    cap_req = 1'b0;
    exp_at(1, "rst_mid_ack", 8'h00, 8'h00, 1'b0);
    tick(2);
    mode = 2'b00;
    din = 8'h00;
    rst_n = 1'b1;
`ifdef MR_LATCH_INVERT_EN
    inv_mask = 8'hF0;
    exp_at(3, "inv_pre", 8'h00, 8'h00, 1'b0);
    exp_at(4, "inv_dout", 8'hF0, 8'hF0, 1'b0);
`else
    exp_at(4, "post_rst_idle", 8'h00, 8'h00, 1'b0);
`endif
    tick(6);

    // Anything still queued was never checked
    tick(2);
    while (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s never checked (due cyc %0d)", sb[0].name, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc %0d", cyc);
    $fatal(1);
  end

endmodule
